// File: rtl/db_qp_scan.sv
// Raster sequencer for db_qp over one 64x64 LCU: reads cbf bits, feeds left qp flags,
// writes returned flags to the flag RAM, and carries the right column into the next LCU.
module db_qp_scan #(
    parameter int BLK_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              lcu_x_first_i,
    input  logic [BLK_W-1:0]  left_seed_i,
    output logic              cbf_rd_en_o,
    output logic [ADDR_W-1:0] cbf_rd_addr_o,
    input  logic              cbf_y_rd_i,
    input  logic              cbf_u_rd_i,
    input  logic              cbf_v_rd_i,
    output logic              cbf_4x4_o,
    output logic              cbf_u_4x4_o,
    output logic              cbf_v_4x4_o,
    output logic              qp_left_o,
    input  logic              qp_flag_i,
    output logic              flag_wr_en_o,
    output logic [ADDR_W-1:0] flag_wr_addr_o,
    output logic              flag_wr_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int                XW       = ADDR_W / 2;
    localparam logic [XW-1:0]     X_LAST   = XW'(BLK_W - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(BLK_W * BLK_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        vld_pipe;   // [0] read, [1] issue, [2] write
    logic [BLK_W-1:0]  colbuf;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            iss_addr <= '0;
            wr_addr  <= '0;
            vld_pipe <= '0;
            colbuf   <= '0;
            done_q   <= 1'b0;
        end else begin
            vld_pipe[2:1] <= vld_pipe[1:0];
            iss_addr      <= cnt;
            wr_addr       <= iss_addr;
            done_q        <= 1'b0;
            // Right-column flags become the left edge of the next LCU in the row.
            if (vld_pipe[2] && wr_addr[XW-1:0] == X_LAST)
                colbuf[wr_addr[ADDR_W-1:XW]] <= qp_flag_i;
            case (state)
                IDLE, DONE: begin
                    // DONE also accepts a start so back-to-back LCUs have no bubble.
                    if (start_i) begin
                        state       <= RUN;
                        vld_pipe[0] <= 1'b1;
                        cnt         <= '0;
                        if (lcu_x_first_i)
                            colbuf <= left_seed_i;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state       <= DRAIN;
                        vld_pipe[0] <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!vld_pipe[1]) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic iss_x0;
    assign iss_x0 = (iss_addr[XW-1:0] == '0);

    assign cbf_rd_en_o    = vld_pipe[0];
    assign cbf_rd_addr_o  = cnt;
    assign cbf_4x4_o      = vld_pipe[1] & cbf_y_rd_i;
    assign cbf_u_4x4_o    = vld_pipe[1] & cbf_u_rd_i;
    assign cbf_v_4x4_o    = vld_pipe[1] & cbf_v_rd_i;
    assign qp_left_o      = vld_pipe[1] & (iss_x0 ? colbuf[iss_addr[ADDR_W-1:XW]] : qp_flag_i);
    assign flag_wr_en_o   = vld_pipe[2];
    assign flag_wr_addr_o = vld_pipe[2] ? wr_addr : '0;
    assign flag_wr_data_o = vld_pipe[2] & qp_flag_i;
    assign busy_o         = (state != IDLE);
    assign done_o         = done_q;
endmodule

// File: tb/tb_db_qp_scan.sv
// Bench for db_qp_scan: cbf RAM and db_qp models around the DUT, scoreboard of issues and writes.
module tb_db_qp_scan;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, lcu_x_first_i;
    logic [15:0] left_seed_i;
    logic        cbf_rd_en_o;
    logic [7:0]  cbf_rd_addr_o;
    logic        cbf_y_rd_i, cbf_u_rd_i, cbf_v_rd_i;
    logic        cbf_4x4_o, cbf_u_4x4_o, cbf_v_4x4_o, qp_left_o;
    logic        qp_flag_i;
    logic        flag_wr_en_o;
    logic [7:0]  flag_wr_addr_o;
    logic        flag_wr_data_o;
    logic        busy_o, done_o;

    always #5 clk = ~clk;

    db_qp_scan #(.BLK_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .lcu_x_first_i(lcu_x_first_i),
        .left_seed_i(left_seed_i), .cbf_rd_en_o(cbf_rd_en_o), .cbf_rd_addr_o(cbf_rd_addr_o),
        .cbf_y_rd_i(cbf_y_rd_i), .cbf_u_rd_i(cbf_u_rd_i), .cbf_v_rd_i(cbf_v_rd_i),
        .cbf_4x4_o(cbf_4x4_o), .cbf_u_4x4_o(cbf_u_4x4_o), .cbf_v_4x4_o(cbf_v_4x4_o),
        .qp_left_o(qp_left_o), .qp_flag_i(qp_flag_i), .flag_wr_en_o(flag_wr_en_o),
        .flag_wr_addr_o(flag_wr_addr_o), .flag_wr_data_o(flag_wr_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // cbf RAM (1-cycle read latency) and db_qp (registered flag, chain broken by any cbf)
    logic ram_y [256];
    logic ram_u [256];
    logic ram_v [256];
    logic iss_tb;

    always @(posedge clk) begin
        if (cbf_rd_en_o) begin
            cbf_y_rd_i <= ram_y[cbf_rd_addr_o];
            cbf_u_rd_i <= ram_u[cbf_rd_addr_o];
            cbf_v_rd_i <= ram_v[cbf_rd_addr_o];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_tb    <= 1'b0;
            qp_flag_i <= 1'b0;
        end else begin
            iss_tb    <= cbf_rd_en_o;
            qp_flag_i <= qp_left_o & ~(cbf_4x4_o | cbf_u_4x4_o | cbf_v_4x4_o);
        end
    end

    typedef struct packed { logic left; logic y; logic u; logic v; } iss_t;
    typedef struct packed { logic [7:0] addr; logic data; } wr_t;

    iss_t        iss_q[$];
    wr_t         wr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ones_cnt = 0;
    logic [15:0] colbuf_m;
    logic [24:0] all_out;

    assign all_out = {cbf_rd_en_o, cbf_rd_addr_o, cbf_4x4_o, cbf_u_4x4_o, cbf_v_4x4_o,
                      qp_left_o, flag_wr_en_o, flag_wr_addr_o, flag_wr_data_o, busy_o, done_o};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference walk of one LCU: pushes every expected issue and write in raster order.
    task automatic model(input bit first, input logic [15:0] seed);
        logic prev, left, flag;
        iss_t e;
        wr_t  w;
        if (first) colbuf_m = seed;
        prev = 1'b0;
        for (int n = 0; n < 256; n++) begin
            int y, x;
            y    = n / 16;
            x    = n % 16;
            left = (x == 0) ? colbuf_m[y] : prev;
            flag = left & ~(ram_y[n] | ram_u[n] | ram_v[n]);
            e    = '{left: left, y: ram_y[n], u: ram_u[n], v: ram_v[n]};
            w    = '{addr: 8'(n), data: flag};
            iss_q.push_back(e);
            wr_q.push_back(w);
            prev = flag;
            if (x == 15) colbuf_m[y] = flag;
        end
    endtask

    always @(negedge clk) begin
        iss_t e;
        wr_t  w;
        if (rst_n) begin
            if (iss_tb) begin
                if (iss_q.size() == 0) chk("iss_unexpected", 32'd1, 32'd0);
                else begin
                    e = iss_q.pop_front();
                    chk("qp_left", 32'(qp_left_o), 32'(e.left));
                    chk("cbf_pass", 32'({cbf_4x4_o, cbf_u_4x4_o, cbf_v_4x4_o}), 32'({e.y, e.u, e.v}));
                end
            end else begin
                chk("iss_idle_zero", 32'({qp_left_o, cbf_4x4_o, cbf_u_4x4_o, cbf_v_4x4_o}), 32'd0);
            end
            if (flag_wr_en_o) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(flag_wr_addr_o), 32'(w.addr));
                    chk("wr_data", 32'(flag_wr_data_o), 32'(w.data));
                    if (flag_wr_data_o) ones_cnt++;
                end
            end else begin
                chk("wr_idle_zero", 32'({flag_wr_addr_o, flag_wr_data_o}), 32'd0);
            end
        end
    end

    task automatic wait_done(input int k0, input int exp_k, input string nm);
        int  k;
        bit  seen;
        k    = k0;
        seen = 1'b0;
        while (k < k0 + 400 && !seen) begin
            if (done_o) begin
                seen = 1'b1;
                chk({nm, "_done_cycle"}, 32'(k), 32'(exp_k));
                chk({nm, "_busy_at_done"}, 32'(busy_o), 32'd1);
            end else begin
                chk({nm, "_busy"}, 32'(busy_o), 32'd1);
                tick();
                k++;
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic post(input string nm, input int exp_ones);
        tick();
        chk({nm, "_idle_busy"}, 32'(busy_o), 32'd0);
        chk({nm, "_done_pulse"}, 32'(done_o), 32'd0);
        chk({nm, "_ones"}, 32'(ones_cnt), 32'(exp_ones));
        chk({nm, "_q_empty"}, 32'(iss_q.size() + wr_q.size()), 32'd0);
        ones_cnt = 0;
    endtask

    task automatic pulse_start(input bit first, input logic [15:0] seed);
        start_i       = 1'b1;
        lcu_x_first_i = first;
        left_seed_i   = seed;
        tick();
        start_i       = 1'b0;
        lcu_x_first_i = 1'b0;
        left_seed_i   = '0;
    endtask

    task automatic run_lcu(input bit first, input logic [15:0] seed, input int exp_ones, input string nm);
        model(first, seed);
        pulse_start(first, seed);
        wait_done(1, 259, nm);
        post(nm, exp_ones);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_y[i] = 1'b0;
            ram_u[i] = 1'b0;
            ram_v[i] = 1'b0;
        end
        cbf_y_rd_i = 1'b0; cbf_u_rd_i = 1'b0; cbf_v_rd_i = 1'b0;
        rst_n = 1'b0; start_i = 1'b0; lcu_x_first_i = 1'b0; left_seed_i = '0;
        colbuf_m = '0;
        repeat (3) tick();
        chk("reset_outputs", 32'(all_out), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", 32'(all_out), 32'd0);

        // 1: all-zero cbf with full seed -> every flag 1
        run_lcu(1'b1, 16'hFFFF, 256, "t1");

        // 2: luma cbf at 0x35 breaks row 3 from x=5; next LCU inherits 0 on row 3
        ram_y[8'h35] = 1'b1;
        run_lcu(1'b1, 16'hFFFF, 245, "t2a");
        run_lcu(1'b0, 16'h0000, 240, "t2b");
        ram_y[8'h35] = 1'b0;

        // 3: seed only row 0; chain carries through colbuf
        run_lcu(1'b1, 16'h0001, 16, "t3a");
        run_lcu(1'b0, 16'hFFFF, 16, "t3b");

        // 4: chroma cbf at x=0 of each row kills everything
        for (int y = 0; y < 16; y++) ram_u[y * 16] = 1'b1;
        run_lcu(1'b1, 16'hFFFF, 0, "t4");
        for (int y = 0; y < 16; y++) ram_u[y * 16] = 1'b0;

        // 5: start while busy ignored; start during done accepted with no gap
        model(1'b1, 16'hFFFF);
        pulse_start(1'b1, 16'hFFFF);
        for (int k = 1; k < 259; k++) begin
            chk("t5_busy", 32'(busy_o), 32'd1);
            if (k == 100) begin
                start_i = 1'b1; lcu_x_first_i = 1'b1; left_seed_i = 16'h0000;
            end
            tick();
            start_i = 1'b0; lcu_x_first_i = 1'b0; left_seed_i = '0;
        end
        chk("t5a_done_259", 32'(done_o), 32'd1);
        chk("t5a_busy_259", 32'(busy_o), 32'd1);
        chk("t5a_ones", 32'(ones_cnt), 32'd256);
        ones_cnt = 0;
        model(1'b0, 16'h0000);
        pulse_start(1'b0, 16'h0000);
        chk("t5b_busy_260", 32'(busy_o), 32'd1);
        chk("t5b_rd_en_260", 32'(cbf_rd_en_o), 32'd1);
        wait_done(260, 518, "t5b");
        post("t5b", 256);

        // 6: reset mid-LCU clears everything including colbuf
        model(1'b1, 16'hFFFF);
        pulse_start(1'b1, 16'hFFFF);
        repeat (129) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", 32'(all_out), 32'd0);
        iss_q.delete();
        wr_q.delete();
        ones_cnt = 0;
        colbuf_m = '0;
        tick();
        tick();
        chk("t6_reset_hold", 32'(all_out), 32'd0);
        rst_n = 1'b1;
        tick();
        run_lcu(1'b0, 16'hFFFF, 0, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
